rs_encoder_lfsr: RTL and testbench
==================================

// Module: rs_encoder_lfsr
// PURPOSE
//  - Systematic RS(31,27) encoder, T=2, over GF(2^5) with p(x)=x^5+x^2+1 (alpha=5'b00010).
//  - Produces the codewords consumed by the RS decoder; shortened codes via K<27.
//  - Message symbols pass through unchanged. The 4 parity symbols follow the message.
//  - g(x)=(x+a)(x+a^2)(x+a^3)(x+a^4)=x^4+a^24x^3+a^19x^2+a^29x+a^10.
//  - Uses gfadder/lcpmult-equivalent GF arithmetic (bit 4 = MSB).
// PARAMETERS
//  K   27        message symbols per codeword, legal 1..27; codeword = K+4 symbols
//  G3  5'd30     g(x) coeff of x^3 (a^24)
//  G2  5'd6      g(x) coeff of x^2 (a^19)
//  G1  5'd9      g(x) coeff of x^1 (a^29)
//  G0  5'd17     g(x) coeff of x^0 (a^10)
// PORTS
//  clock          in   1  rising-edge clock
//  reset_n        in   1  asynchronous active-low reset
//  in_valid       in   1  in_data holds a message symbol
//  in_ready       out  1  encoder accepts a symbol this cycle (combinational)
//  in_data        in   5  message symbol, first symbol = highest-degree coefficient
//  out_valid      out  1  out_data valid
//  out_ready      in   1  downstream accepts out_data this cycle
//  out_data       out  5  codeword symbol, highest degree first
//  out_parity     out  1  out_data is a parity symbol
//  out_last       out  1  out_data is the final symbol (last parity) of the codeword
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=MSG, msg_cnt=0, par_cnt=0, r0..r3=0.
//    Also out_valid=0, out_data=0, out_parity=0, out_last=0. in_ready=1 once released.
//  - out_free = !out_valid | out_ready. in_ready = (state==MSG) & out_free.
//  - Accept = in_valid & in_ready. On accept, in one edge:
//    - out_data<=in_data, out_valid<=1, out_parity<=0, out_last<=0.
//    - fb=in_data^r3; r3<=r2^fb*G3; r2<=r1^fb*G2; r1<=r0^fb*G1; r0<=fb*G0.
//      Products are GF(2^5) mod p(x); additions are XOR.
//    - msg_cnt++. If msg_cnt==K-1: msg_cnt<=0 and state<=PAR.
//  - MSG with out_free & !in_valid: out_valid<=0. The LFSR and counters hold.
//  - PAR state, on each cycle with out_free:
//    - out_data<=r3, out_valid<=1, out_parity<=1.
//    - Shift r3<=r2, r2<=r1, r1<=r0, r0<=0; par_cnt++.
//    - On par_cnt==3: out_last<=1, par_cnt<=0, state<=MSG. The LFSR is zero afterwards.
//  - When !out_free, all state, LFSR and output registers hold. Output fields never change while out_valid&!out_ready.
//  - Latency: an accepted symbol appears on out_data the next cycle.
//    The first parity symbol is registered on the edge after the K-th symbol leaves the output register, or with it if out_ready=1.
//  - Throughput with out_ready=1 and in_valid=1: K+4 cycles per codeword. in_ready=0 for exactly 4 cycles per codeword.
//  - Back-to-back codewords: the first message symbol of the next block is accepted the cycle after the 4th parity is registered (state=MSG).
//  - States: MSG -(K-th accept)-> PAR -(4th parity loaded)-> MSG. Only two states; illegal encodings recover to MSG on the next edge.
//  - Reset mid-codeword discards the partial codeword. Encoding restarts with a new message at msg_cnt=0.
// TESTING
//  - All-zero message, K=27, out_ready=1: 27 zeros then parity 0,0,0,0. out_parity=1 on the last 4 only; out_last only on the 31st.
//  - Message m(x)=1 (26 zeros then 5'd1): parity out = 30,6,9,17.
//  - Same m(x)=1 with out_ready toggling 1010...: same 31 symbols in order. Fields stable while stalled; in_ready=0 while out_valid&!out_ready.
//  - Feed the encoder output into the RS decoder with 0, 1 and 2 injected symbol errors.
//    The decoder returns the original 27 symbols. Also check syndromes S1..S4 = 0 on the clean codeword.
//  - Two back-to-back random codewords, in_valid=1 and out_ready=1: 62 output cycles.
//    in_ready low for cycles 28-31 and 59-62 only. Second block parity is independent of the first block.
//  - Assert reset_n=0 after 10 symbols, release, then send m(x)=1: output = 27 symbols + 30,6,9,17, with no stale LFSR contribution.

Source files
------------

// File: rtl/rs_encoder_lfsr.sv
// Systematic RS(31,27) encoder over GF(2^5), p(x) = x^5 + x^2 + 1.
// Message symbols stream through unchanged, followed by four LFSR parity symbols.
module rs_encoder_lfsr #(
    parameter int         K  = 27,
    parameter logic [4:0] G3 = 5'd30,
    parameter logic [4:0] G2 = 5'd6,
    parameter logic [4:0] G1 = 5'd9,
    parameter logic [4:0] G0 = 5'd17
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_data,
    output logic       out_parity,
    output logic       out_last
);

    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    // One-hot pair so that the two unused codes can be detected and recovered.
    typedef enum logic [1:0] {
        ST_MSG = 2'b01,
        ST_PAR = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [1:0]       par_cnt_q, par_cnt_d;
    logic [4:0]       r0_q, r1_q, r2_q, r3_q;
    logic [4:0]       r0_d, r1_d, r2_d, r3_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       out_data_q, out_data_d;
    logic             out_parity_q, out_parity_d;
    logic             out_last_q, out_last_d;
    logic             out_free;
    logic [4:0]       fb;

    // GF(2^5) multiply: shift-and-add, reducing x^5 to x^2 + 1.
    function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] acc;
        logic [4:0] sh;
        acc = 5'd0;
        sh  = a;
        for (int i = 0; i < 5; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[3:0], 1'b0} ^ (sh[4] ? 5'b00101 : 5'b00000);
        end
        return acc;
    endfunction

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == ST_MSG) && out_free;
    assign fb       = in_data ^ r3_q;

    // NOTE: every _d gets its hold value first, so no path through the case
    // statement leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        msg_cnt_d    = msg_cnt_q;
        par_cnt_d    = par_cnt_q;
        r0_d         = r0_q;
        r1_d         = r1_q;
        r2_d         = r2_q;
        r3_d         = r3_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        out_last_d   = out_last_q;

        unique case (state_q)
            ST_MSG: begin
                if (out_free) begin
                    if (in_valid) begin
                        out_data_d   = in_data;
                        out_valid_d  = 1'b1;
                        out_parity_d = 1'b0;
                        out_last_d   = 1'b0;
                        r3_d         = r2_q ^ gf_mul(fb, G3);
                        r2_d         = r1_q ^ gf_mul(fb, G2);
                        r1_d         = r0_q ^ gf_mul(fb, G1);
                        r0_d         = gf_mul(fb, G0);
                        if (msg_cnt_q == CNT_W'(K - 1)) begin
                            msg_cnt_d = '0;
                            state_d   = ST_PAR;
                        end else begin
                            msg_cnt_d = msg_cnt_q + 1'b1;
                        end
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            ST_PAR: begin
                if (out_free) begin
                    out_data_d   = r3_q;
                    out_valid_d  = 1'b1;
                    out_parity_d = 1'b1;
                    out_last_d   = (par_cnt_q == 2'd3);
                    r3_d         = r2_q;
                    r2_d         = r1_q;
                    r1_d         = r0_q;
                    r0_d         = 5'd0;
                    par_cnt_d    = par_cnt_q + 2'd1;
                    if (par_cnt_q == 2'd3) state_d = ST_MSG;
                end
            end
            default: begin
                state_d = ST_MSG;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_MSG;
            msg_cnt_q    <= '0;
            par_cnt_q    <= 2'd0;
            r0_q         <= 5'd0;
            r1_q         <= 5'd0;
            r2_q         <= 5'd0;
            r3_q         <= 5'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 5'd0;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            msg_cnt_q    <= msg_cnt_d;
            par_cnt_q    <= par_cnt_d;
            r0_q         <= r0_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            r3_q         <= r3_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_rs_encoder_lfsr.sv
// Directed bench for rs_encoder_lfsr: known parity vectors, stalls, back-to-back
// blocks and mid-block reset; codewords are also checked for zero syndromes.
module tb_rs_encoder_lfsr;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] in_data  = 5'd0;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_parity;
    logic       out_last;

    int n_total = 0;
    int n_bad   = 0;

    logic [4:0] exp_t [0:30];
    int         log_t [0:31];
    logic [4:0] tx_msg  [$];
    logic [4:0] rx_data [$];
    logic       rx_par  [$];
    logic       rx_last [$];
    logic       ir_trace[$];

    rs_encoder_lfsr #(.K(27)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_last   (out_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Log/antilog multiply, independent of the shift-and-add form in the design.
    function automatic logic [4:0] gmul(input logic [4:0] a, input logic [4:0] b);
        if (a == 5'd0 || b == 5'd0) return 5'd0;
        return exp_t[(log_t[a] + log_t[b]) % 31];
    endfunction

    // Codeword evaluated at alpha^j, highest-degree symbol first (Horner).
    function automatic logic [4:0] syndrome(input int j, input int base);
        logic [4:0] s;
        s = 5'd0;
        for (int i = 0; i < 31; i++) s = gmul(s, exp_t[j]) ^ rx_data[base + i];
        return s;
    endfunction

    // mode 0: out_ready held high; mode 1: out_ready toggles 1,0,1,0...
    task automatic run_stream(input int mode, input int n_out);
        int         idx;
        int         cyc;
        logic       stalled;
        logic [7:0] held;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        held = 8'd0;
        rx_data.delete();
        rx_par.delete();
        rx_last.delete();
        ir_trace.delete();
        while (rx_data.size() < n_out && cyc < 1000) begin
            @(negedge clock);
            if (stalled)
                check("stall_hold", int'({out_valid, out_parity, out_last, out_data}), int'(held));
            in_valid  = (idx < tx_msg.size());
            in_data   = in_valid ? tx_msg[idx] : 5'd0;
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            #1;
            ir_trace.push_back(in_ready);
            stalled = out_valid && !out_ready;
            if (stalled) begin
                held = {out_valid, out_parity, out_last, out_data};
                check("ready_stall", int'(in_ready), 0);
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                rx_data.push_back(out_data);
                rx_par.push_back(out_parity);
                rx_last.push_back(out_last);
            end
            cyc++;
        end
        if (rx_data.size() < n_out) check("timeout", rx_data.size(), n_out);
        in_valid = 1'b0;
    endtask

    // Checks one 31-symbol codeword at rx offset base against tx_msg offset moff.
    task automatic verify_block(input int base, input int moff, input string name);
        for (int i = 0; i < 31; i++) begin
            if (i < 27)
                check($sformatf("%s_msg[%0d]", name, i), int'(rx_data[base + i]), int'(tx_msg[moff + i]));
            check($sformatf("%s_par[%0d]", name, i), int'(rx_par[base + i]), (i >= 27) ? 1 : 0);
            check($sformatf("%s_last[%0d]", name, i), int'(rx_last[base + i]), (i == 30) ? 1 : 0);
        end
        for (int j = 1; j <= 4; j++)
            check($sformatf("%s_synd%0d", name, j), int'(syndrome(j, base)), 0);
    endtask

    task automatic check_parity(input string name, input int p3, input int p2, input int p1, input int p0);
        check({name, "_p0"}, int'(rx_data[27]), p3);
        check({name, "_p1"}, int'(rx_data[28]), p2);
        check({name, "_p2"}, int'(rx_data[29]), p1);
        check({name, "_p3"}, int'(rx_data[30]), p0);
    endtask

    task automatic load_unit_msg();
        tx_msg.delete();
        for (int i = 0; i < 26; i++) tx_msg.push_back(5'd0);
        tx_msg.push_back(5'd1);
    endtask

    initial begin
        logic [5:0] t;
        t = 6'd1;
        for (int i = 0; i < 31; i++) begin
            exp_t[i] = t[4:0];
            log_t[t[4:0]] = i;
            t = {t[4:0], 1'b0};
            if (t[5]) t = t ^ 6'b100101;
        end
        log_t[0] = 0;

        // Reset state
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_parity", int'(out_parity), 0);
        check("rst_out_last", int'(out_last), 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // All-zero message
        tx_msg.delete();
        for (int i = 0; i < 27; i++) tx_msg.push_back(5'd0);
        run_stream(0, 31);
        if (rx_data.size() == 31) begin
            verify_block(0, 0, "zero");
            check_parity("zero", 0, 0, 0, 0);
        end

        // m(x) = 1: parity equals g(x) low coefficients
        load_unit_msg();
        run_stream(0, 31);
        if (rx_data.size() == 31) begin
            verify_block(0, 0, "unit");
            check_parity("unit", 30, 6, 9, 17);
        end

        // m(x) = 1 with out_ready toggling
        load_unit_msg();
        run_stream(1, 31);
        if (rx_data.size() == 31) begin
            verify_block(0, 0, "toggle");
            check_parity("toggle", 30, 6, 9, 17);
        end

        // Two back-to-back codewords; second block ends with m(x)=1 so its
        // parity must not depend on the random first block
        tx_msg.delete();
        for (int i = 0; i < 27; i++) tx_msg.push_back(5'($urandom_range(0, 31)));
        for (int i = 0; i < 26; i++) tx_msg.push_back(5'd0);
        tx_msg.push_back(5'd1);
        run_stream(0, 62);
        if (rx_data.size() == 62) begin
            verify_block(0, 0, "b2b_a");
            verify_block(31, 27, "b2b_b");
            check("b2b_b_p0", int'(rx_data[58]), 30);
            check("b2b_b_p3", int'(rx_data[61]), 17);
            for (int c = 1; c <= 62; c++)
                check($sformatf("b2b_in_ready[%0d]", c), int'(ir_trace[c - 1]),
                      ((c >= 28 && c <= 31) || (c >= 59 && c <= 62)) ? 0 : 1);
        end

        // Reset after 10 symbols, then m(x)=1 must give clean parity
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            in_valid  = 1'b1;
            in_data   = 5'(i + 3);
            out_ready = 1'b1;
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_data", int'(out_data), 0);
        @(negedge clock);
        reset_n = 1'b1;
        load_unit_msg();
        run_stream(0, 31);
        if (rx_data.size() == 31) begin
            verify_block(0, 0, "post_rst");
            check_parity("post_rst", 30, 6, 9, 17);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
